// File: rtl/freq_meas_if.sv
// Handshake bundle between the frequency-measurement sequencer and its
// top-level requester and the period, divider and bin2bcd datapath blocks.
interface freq_meas_if;
  logic        start;
  logic        ready;
  logic        done_tick;
  logic        err;
  logic        prd_start;
  logic        prd_done;
  logic [19:0] prd;
  logic        div_start;
  logic        div_done;
  logic [19:0] dvnd;
  logic [19:0] dvsr;
  logic [19:0] quo;
  logic        b2b_start;
  logic        b2b_done;
  logic [19:0] freq;

  modport master (
    input  start, prd_done, prd, div_done, quo, b2b_done,
    output ready, done_tick, err, prd_start, div_start,
    output dvnd, dvsr, b2b_start, freq
  );

  modport slave (
    output start, prd_done, prd, div_done, quo, b2b_done,
    input  ready, done_tick, err, prd_start, div_start,
    input  dvnd, dvsr, b2b_start, freq
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Sequencer: period count -> divide -> bin2bcd, with watchdog and /0 guard.
// FREQ_MEAS_CONTINUOUS_EN: loop DONE -> COUNT forever after one start.
module freq_meas_ctrl #(
  parameter int DIVIDEND       = 1_000_000,
  parameter int TIMEOUT_CYCLES = 200_000_000,
  parameter int TO_W           = 28
) (
  input  logic        clk,
  input  logic        reset,
  freq_meas_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    FRQ,
    B2B,
    DONE
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [TO_W-1:0] wd, wd_n;
  logic            err_q, err_n;
  logic [19:0]     dvsr_q, dvsr_n;
  logic [19:0]     freq_q, freq_n;
  logic            prd_st, prd_st_n;
  logic            div_st, div_st_n;
  logic            b2b_st, b2b_st_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wd     <= '0;
      err_q  <= 1'b0;
      dvsr_q <= '0;
      freq_q <= '0;
      prd_st <= 1'b0;
      div_st <= 1'b0;
      b2b_st <= 1'b0;
    end else begin
      state  <= state_n;
      wd     <= wd_n;
      err_q  <= err_n;
      dvsr_q <= dvsr_n;
      freq_q <= freq_n;
      prd_st <= prd_st_n;
      div_st <= div_st_n;
      b2b_st <= b2b_st_n;
    end
  end

  always_comb begin
    state_n  = state;
    wd_n     = wd;
    err_n    = err_q;
    dvsr_n   = dvsr_q;
    freq_n   = freq_q;
    prd_st_n = 1'b0;
    div_st_n = 1'b0;
    b2b_st_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n  = COUNT;
          wd_n     = '0;
          err_n    = 1'b0;
          prd_st_n = 1'b1;
        end
      end
      COUNT: begin
        wd_n = wd + 1'b1;
        // a period arriving on the final watchdog cycle still wins
        if (bus.prd_done) begin
          dvsr_n = bus.prd;
          if (bus.prd == '0) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            state_n  = FRQ;
            div_st_n = 1'b1;
          end
        end else if (wd == WD_LAST) begin
          err_n   = 1'b1;
          state_n = DONE;
        end
      end
      FRQ: begin
        if (bus.div_done) begin
          freq_n   = bus.quo;
          state_n  = B2B;
          b2b_st_n = 1'b1;
        end
      end
      B2B: begin
        if (bus.b2b_done) state_n = DONE;
      end
      DONE: begin
`ifdef FREQ_MEAS_CONTINUOUS_EN
        state_n  = COUNT;
        wd_n     = '0;
        err_n    = 1'b0;
        prd_st_n = 1'b1;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done_tick = (state == DONE);
  assign bus.err       = err_q;
  assign bus.prd_start = prd_st;
  assign bus.div_start = div_st;
  assign bus.b2b_start = b2b_st;
  assign bus.dvnd      = 20'(DIVIDEND);
  assign bus.dvsr      = dvsr_q;
  assign bus.freq      = freq_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed + randomized bench for freq_meas_ctrl with a behavioural
// model of the measurement outcome (err / dvsr / freq / pulse counts).
module tb_freq_meas_ctrl;
  localparam int DIVIDEND = 1_000_000;
  localparam int TO_CYC   = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  freq_meas_if bus ();

  freq_meas_ctrl #(
    .DIVIDEND(DIVIDEND),
    .TIMEOUT_CYCLES(TO_CYC),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc = 0;
  int n_prd, n_div, n_b2b, n_done, n_ovl;
  int t_prd, t_div, t_b2b, t_done;

  logic [19:0] m_freq = '0;
  logic [19:0] m_dvsr = '0;
  logic        m_err  = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (bus.prd_start) begin n_prd++; t_prd = cyc; end
    if (bus.div_start) begin n_div++; t_div = cyc; end
    if (bus.b2b_start) begin n_b2b++; t_b2b = cyc; end
    if (bus.done_tick) begin n_done++; t_done = cyc; end
    if (32'(bus.prd_start) + 32'(bus.div_start)
        + 32'(bus.b2b_start) > 1) n_ovl++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon;
    n_prd = 0; n_div = 0; n_b2b = 0; n_done = 0;
    t_prd = 0; t_div = 0; t_b2b = 0; t_done = 0;
  endtask

  task automatic drive_back(input logic [19:0] p, input int dp,
                            input int dd, input int db,
                            input bit stray);
    logic [19:0] q;
    repeat (dp) tick;
    bus.prd = p; bus.prd_done = 1'b1; tick; bus.prd_done = 1'b0;
    if (p != '0) begin
      q = 20'(DIVIDEND / int'(p));
      if (stray) begin
        bus.start = 1'b1; bus.b2b_done = 1'b1; bus.prd_done = 1'b1;
        tick;
        bus.start = 1'b0; bus.b2b_done = 1'b0; bus.prd_done = 1'b0;
        chk("stray_busy", 32'(bus.ready), 32'd0);
        chk("stray_nob2b", 32'(bus.b2b_start), 32'd0);
      end
      repeat (dd) tick;
      bus.quo = q; bus.div_done = 1'b1; tick; bus.div_done = 1'b0;
      repeat (db) tick;
      bus.b2b_done = 1'b1; tick; bus.b2b_done = 1'b0;
      m_err = 1'b0; m_dvsr = p; m_freq = q;
    end else begin
      m_err = 1'b1; m_dvsr = '0;
    end
  endtask

  task automatic measure(input logic [19:0] p, input int dp,
                         input int dd, input int db,
                         input bit to, input bit stray);
    int cnt;
    bit ok;
    chk("ready_idle", 32'(bus.ready), 32'd1);
    clr_mon();
    bus.start = 1'b1; tick; bus.start = 1'b0;
    chk("prd_start", 32'(bus.prd_start), 32'd1);
    if (to) m_err = 1'b1;
    else drive_back(p, dp, dd, db, stray);
    cnt = 0;
    while (bus.done_tick !== 1'b1 && cnt < 200) begin
      tick;
      cnt++;
    end
    chk("done_lat", 32'(cnt), to ? 32'(TO_CYC) : 32'd0);
    chk("err", 32'(bus.err), 32'(m_err));
    chk("freq", 32'(bus.freq), 32'(m_freq));
    chk("dvsr", 32'(bus.dvsr), 32'(m_dvsr));
    tick;
    chk("done_once", 32'(bus.done_tick), 32'd0);
    chk("ready_back", 32'(bus.ready), 32'd1);
    chk("n_prd", 32'(n_prd), 32'd1);
    chk("n_div", 32'(n_div), (to || p == '0) ? 32'd0 : 32'd1);
    chk("n_b2b", 32'(n_b2b), (to || p == '0) ? 32'd0 : 32'd1);
    chk("n_done", 32'(n_done), 32'd1);
    if (!to && p != '0) begin
      ok = (t_prd < t_div) && (t_div < t_b2b) && (t_b2b < t_done);
      chk("order", 32'(ok), 32'd1);
    end
  endtask

  initial begin
    logic [19:0] rp;
    bus.start = 1'b0; bus.prd_done = 1'b0; bus.prd = '0;
    bus.div_done = 1'b0; bus.quo = '0; bus.b2b_done = 1'b0;
    n_ovl = 0;
    clr_mon();
    repeat (3) tick;
    reset = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_starts", 32'({bus.prd_start, bus.div_start,
                           bus.b2b_start}), 32'd0);
    chk("rst_done", 32'(bus.done_tick), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_freq", 32'(bus.freq), 32'd0);
    chk("rst_dvsr", 32'(bus.dvsr), 32'd0);
    chk("dvnd", 32'(bus.dvnd), 32'(DIVIDEND));
    tick;

`ifdef FREQ_MEAS_CONTINUOUS_EN
    clr_mon();
    bus.start = 1'b1; tick; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("cont_prd_start", 32'(bus.prd_start), 32'd1);
      chk("cont_busy", 32'(bus.ready), 32'd0);
      rp = 20'($urandom_range(1, 999_999));
      drive_back(rp, int'($urandom_range(0, 8)),
                 int'($urandom_range(0, 8)),
                 int'($urandom_range(0, 8)), 1'b0);
      chk("cont_done", 32'(bus.done_tick), 32'd1);
      chk("cont_freq", 32'(bus.freq), 32'(m_freq));
      chk("cont_err", 32'(bus.err), 32'd0);
      tick;
    end
    chk("cont_prd_last", 32'(bus.prd_start), 32'd1);
    chk("cont_n_done", 32'(n_done), 32'd3);
    reset = 1'b1; tick; reset = 1'b0;
    chk("cont_rst_ready", 32'(bus.ready), 32'd1);
`else
    measure(20'd1000, 3, 4, 2, 1'b0, 1'b0);
    measure(20'd0, 0, 0, 0, 1'b1, 1'b0);
    measure(20'd0, 2, 0, 0, 1'b0, 1'b0);
    measure(20'd500, 1, 2, 3, 1'b0, 1'b0);
    measure(20'd250, 0, 3, 1, 1'b0, 1'b1);
    measure(20'd777, TO_CYC - 1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rp = 20'($urandom_range(1, 999_999));
      measure(rp, int'($urandom_range(0, 30)),
              int'($urandom_range(0, 10)),
              int'($urandom_range(0, 10)), 1'b0, 1'b0);
    end

    bus.start = 1'b1; tick; bus.start = 1'b0;
    bus.prd = 20'd300; bus.prd_done = 1'b1; tick; bus.prd_done = 1'b0;
    chk("pre_rst_div", 32'(bus.div_start), 32'd1);
    reset = 1'b1; tick; reset = 1'b0;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_starts", 32'({bus.prd_start, bus.div_start,
                               bus.b2b_start}), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    chk("mid_rst_freq", 32'(bus.freq), 32'd0);
    bus.quo = 20'd77; bus.div_done = 1'b1; tick; bus.div_done = 1'b0;
    chk("late_div_ready", 32'(bus.ready), 32'd1);
    chk("late_div_b2b", 32'(bus.b2b_start), 32'd0);
    chk("late_div_freq", 32'(bus.freq), 32'd0);
    tick;
    chk("late_div_done", 32'(bus.done_tick), 32'd0);
`endif
    chk("no_overlap", 32'(n_ovl), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
